// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and arbiter FSM states.
// Consumed by alu_arbiter (build option ALU_ARB_FIXED_PRIO_EN lives there).
package alu_pkg;

  localparam int ALU_DATA_W = 32;
  localparam int ALU_OP_W   = 3;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_AND = 3'b001,
    ALU_NOR = 3'b010,
    ALU_SLT = 3'b011,
    ALU_OR  = 3'b100,
    ALU_SUB = 3'b101
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/alu_rr_grant.sv
// Two-way grant: a lone requester wins; a tie is broken by rr_ptr_i (or always by
// requester 0 when ALU_ARB_FIXED_PRIO_EN is defined).
module alu_rr_grant (
  input  logic [1:0] valid_i,
`ifndef ALU_ARB_FIXED_PRIO_EN
  input  logic       rr_ptr_i,
`endif
  output logic [1:0] grant_o
);

  always_comb begin
    grant_o = 2'b00;
    if (valid_i == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_o = 2'b01;
`else
      grant_o = rr_ptr_i ? 2'b10 : 2'b01;
`endif
    end else begin
      grant_o = valid_i;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two valid/ready requesters: IDLE -> EXEC -> RESP,
// one op in flight, rsp 2 cycles after grant. ALU_ARB_FIXED_PRIO_EN: req0 wins ties.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_W = alu_pkg::ALU_DATA_W,
  parameter int OP_W   = alu_pkg::ALU_OP_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [2*OP_W-1:0]   req_op,
  input  logic [2*DATA_W-1:0] req_a,
  input  logic [2*DATA_W-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic                rsp_id,
  output logic [DATA_W-1:0]   rsp_result,
  output logic                rsp_zero,
  output logic [DATA_W-1:0]   alu_src_a,
  output logic [DATA_W-1:0]   alu_src_b,
  output logic [OP_W-1:0]     ALUOp,
  input  logic [DATA_W-1:0]   alu_output,
  input  logic                Zero
);

  arb_state_e        state_q, state_d;
  logic [1:0]        grant;
  logic              gnt_id;
  logic              take;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] a_q, b_q;
  logic              id_q;
  logic [DATA_W-1:0] result_q;
  logic              zero_q;

`ifndef ALU_ARB_FIXED_PRIO_EN
  logic rr_ptr_q, rr_ptr_d;

  alu_rr_grant u_grant (
    .valid_i  (req_valid),
    .rr_ptr_i (rr_ptr_q),
    .grant_o  (grant)
  );

  // The pointer only moves on contention, so a lone request never steals the next tie.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (take && req_valid == 2'b11) rr_ptr_d = ~gnt_id;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rr_ptr_q <= 1'b0;
    else     rr_ptr_q <= rr_ptr_d;
  end
`else
  alu_rr_grant u_grant (
    .valid_i (req_valid),
    .grant_o (grant)
  );
`endif

  assign gnt_id = grant[1];
  assign take   = (state_q == ST_IDLE) && (grant != 2'b00);

  always_comb begin
    state_d   = state_q;
    req_ready = 2'b00;
    case (state_q)
      ST_IDLE: begin
        req_ready = grant;
        if (grant != 2'b00) state_d = ST_EXEC;
      end
      ST_EXEC: state_d = ST_RESP;
      ST_RESP: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      op_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      id_q     <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (take) begin
        op_q <= gnt_id ? req_op[2*OP_W-1:OP_W]     : req_op[OP_W-1:0];
        a_q  <= gnt_id ? req_a[2*DATA_W-1:DATA_W]  : req_a[DATA_W-1:0];
        b_q  <= gnt_id ? req_b[2*DATA_W-1:DATA_W]  : req_b[DATA_W-1:0];
        id_q <= gnt_id;
      end
      if (state_q == ST_EXEC) begin
        result_q <= alu_output;
        zero_q   <= Zero;
      end
    end
  end

  // Operands stay on the ALU until the response drains; the ALU sees zeros while idle.
  assign alu_src_a  = (state_q != ST_IDLE) ? a_q  : '0;
  assign alu_src_b  = (state_q != ST_IDLE) ? b_q  : '0;
  assign ALUOp      = (state_q != ST_IDLE) ? op_q : '0;

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_zero   = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: a predictor queues expected responses on each grant,
// a monitor pops and compares them; directed cases followed by randomized traffic.
module tb_alu_arbiter;

  localparam int DW = 32;
  localparam int OW = 3;
`ifdef ALU_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [1:0]      req_valid = 2'b00;
  logic [1:0]      req_ready;
  logic [2*OW-1:0] req_op = '0;
  logic [2*DW-1:0] req_a = '0;
  logic [2*DW-1:0] req_b = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic            rsp_id;
  logic [DW-1:0]   rsp_result;
  logic            rsp_zero;
  logic [DW-1:0]   alu_src_a, alu_src_b, alu_output;
  logic [OW-1:0]   ALUOp;
  logic            Zero;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int bp_mode = 0;  // 0: always ready, 1: never ready, 2: random

  alu_arbiter dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ALUOp(ALUOp),
    .alu_output(alu_output), .Zero(Zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] ref_alu(input logic [2:0] op, input logic [DW-1:0] a,
                                            input logic [DW-1:0] b);
    case (op)
      3'b000:  return a + b;
      3'b001:  return a & b;
      3'b010:  return ~(a | b);
      3'b011:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'b100:  return a | b;
      3'b101:  return a - b;
      default: return '0;
    endcase
  endfunction

  // Behavioural stand-in for the shared ALU.
  always_comb begin
    alu_output = ref_alu(ALUOp, alu_src_a, alu_src_b);
    Zero       = (alu_output == '0);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic          id;
    logic [DW-1:0] res;
    logic          zero;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    int            acc;
  } exp_t;

  exp_t sb[$];
  logic rr_m = 1'b0;

  // Predictor: which requester should be granted now, and what it will get back.
  always @(negedge clk) begin : pred
    logic [1:0]    eg;
    logic          w;
    logic [2:0]    op;
    logic [DW-1:0] a, b, r;
    if (rst) begin
      sb.delete();
      rr_m = 1'b0;
    end else begin
      eg = 2'b00;
      if (sb.size() == 0 && req_valid != 2'b00) begin
        if (req_valid == 2'b11) eg = (FIXED || !rr_m) ? 2'b01 : 2'b10;
        else                    eg = req_valid;
      end
      chk("req_ready", req_ready, eg);
      if (sb.size() == 0) begin
        chk("alu_idle", {ALUOp, alu_src_a, alu_src_b} == '0, 1'b1);
      end else if (cyc == sb[0].acc + 1) begin
        chk("alu_op",    ALUOp,     sb[0].op);
        chk("alu_src_a", alu_src_a, sb[0].a);
        chk("alu_src_b", alu_src_b, sb[0].b);
      end
      if (eg != 2'b00) begin
        w  = eg[1];
        op = req_op[w*OW +: OW];
        a  = req_a[w*DW +: DW];
        b  = req_b[w*DW +: DW];
        r  = ref_alu(op, a, b);
        sb.push_back('{id: w, res: r, zero: (r == '0), op: op, a: a, b: b, acc: cyc});
        if (req_valid == 2'b11) rr_m = ~w;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the oldest expectation.
  always begin
    @(negedge clk);
    #1;
    if (!rst) begin
      if (sb.size() == 0) begin
        chk("rsp_valid_idle", rsp_valid, 1'b0);
      end else if (cyc - sb[0].acc < 2) begin
        chk("rsp_valid_early", rsp_valid, 1'b0);
      end else begin
        chk("rsp_valid", rsp_valid, 1'b1);
        if (rsp_valid) begin
          chk("rsp_id",     rsp_id,     sb[0].id);
          chk("rsp_result", rsp_result, sb[0].res);
          chk("rsp_zero",   rsp_zero,   sb[0].zero);
          if (rsp_ready) void'(sb.pop_front());
        end else begin
          void'(sb.pop_front());
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    case (bp_mode)
      0:       rsp_ready = 1'b1;
      1:       rsp_ready = 1'b0;
      default: rsp_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic set_req(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                         input logic [DW-1:0] b);
    req_op[i*OW +: OW] = op;
    req_a[i*DW +: DW]  = a;
    req_b[i*DW +: DW]  = b;
    req_valid[i]       = 1'b1;
  endtask

  // Presents a request and holds it until it is accepted; returns just after the grant edge.
  task automatic issue(input int i, input logic [2:0] op, input logic [DW-1:0] a,
                       input logic [DW-1:0] b);
    set_req(i, op, a, b);
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (req_ready[i]) begin
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
        return;
      end
    end
    chk($sformatf("grant_timeout_%0d", i), 1'b0, 1'b1);
    req_valid[i] = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (rsp_valid) return;
    end
    chk("rsp_timeout", 1'b0, 1'b1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 2'b00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_id",    rsp_id, 1'b0);
    chk("rst_rsp_res",   rsp_result, 32'd0);
    chk("rst_rsp_zero",  rsp_zero, 1'b0);
    chk("rst_alu_ports", {ALUOp, alu_src_a, alu_src_b} == '0, 1'b1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single request, latency and value.
    issue(0, 3'b000, 32'd5, 32'd7);
    wait_rsp();
    chk("add_result", rsp_result, 32'd12);
    chk("add_zero",   rsp_zero, 1'b0);
    chk("add_id",     rsp_id, 1'b0);
    @(posedge clk);
    #1;

    // Tie: req0 first, then req1; a second tie goes to req1 under round-robin.
    fork
      issue(0, 3'b101, 32'd9, 32'd9);
      issue(1, 3'b100, 32'hF0, 32'h0F);
    join
    wait_rsp();
    chk("tie_or_id",     rsp_id, 1'b1);
    chk("tie_or_result", rsp_result, 32'hFF);
    @(posedge clk);
    #1;
    set_req(0, 3'b001, 32'h3, 32'h6);
    set_req(1, 3'b011, 32'hFFFF_FFFF, 32'd1);
    @(negedge clk);
    chk("tie2_grant", req_ready, FIXED ? 2'b01 : 2'b10);
    fork
      issue(0, 3'b001, 32'h3, 32'h6);
      issue(1, 3'b011, 32'hFFFF_FFFF, 32'd1);
    join
    wait_rsp();
    @(posedge clk);
    #1;

    // Backpressure: result held, no new grant while the response is pending.
    bp_mode = 1;
    @(posedge clk);
    #1;
    issue(0, 3'b001, 32'hFF00, 32'h0FF0);
    set_req(1, 3'b010, 32'h0, 32'h0);
    wait_rsp();
    repeat (5) begin
      @(negedge clk);
      chk("bp_result", rsp_result, 32'h0F00);
      chk("bp_ready",  req_ready, 2'b00);
    end
    bp_mode = 0;
    issue(1, 3'b010, 32'h0, 32'h0);
    wait_rsp();
    chk("nor_result", rsp_result, 32'hFFFF_FFFF);
    @(posedge clk);
    #1;

    // Undefined opcode is forwarded and yields zero.
    issue(0, 3'b111, 32'd123, 32'd456);
    wait_rsp();
    chk("undef_result", rsp_result, 32'd0);
    chk("undef_zero",   rsp_zero, 1'b1);
    @(posedge clk);
    #1;

    // Reset while the op is in EXEC drops it.
    issue(1, 3'b000, 32'd1, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid",  rsp_valid, 1'b0);
    chk("mid_rst_ready",  req_ready, 2'b00);
    chk("mid_rst_rsp",    {rsp_id, rsp_zero, rsp_result} == '0, 1'b1);
    chk("mid_rst_alu",    {ALUOp, alu_src_a, alu_src_b} == '0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("post_rst_valid", rsp_valid, 1'b0);
    end

    // Randomized traffic with random consumer backpressure.
    bp_mode = 2;
    for (int n = 0; n < 150; n++) begin
      automatic logic [1:0]    m  = 2'($urandom_range(1, 3));
      automatic logic [2:0]    o0 = 3'($urandom_range(0, 7));
      automatic logic [2:0]    o1 = 3'($urandom_range(0, 7));
      automatic logic [DW-1:0] a0 = $urandom;
      automatic logic [DW-1:0] b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      automatic logic [DW-1:0] a1 = $urandom_range(0, 20);
      automatic logic [DW-1:0] b1 = $urandom_range(0, 20);
      fork
        begin if (m[0]) issue(0, o0, a0, b0); end
        begin if (m[1]) issue(1, o1, a1, b1); end
      join
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end
    bp_mode = 0;
    repeat (10) @(posedge clk);
    chk("drain_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
